sp_port_arbiter: RTL and testbench

- Shares the single secondary-port (SP) memory interface (sp_en, wr_rd_sp, SPA, SPD_OUT, SPD_IN) between two masters.
  - Master 0 is the DMAC SP side.
  - Master 1 is the processor/host side.
- Round-robin grant with bounded bursts; honours stall_ext.
- Routes read data back to the master that issued each read, including across owner switches.

---
 rtl/sp_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sp_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sp_port_arbiter.sv
// Two-master arbiter for the single secondary-port (SP) memory interface.
// It grants round-robin with bounded bursts and routes each read return to the master that issued it.
module sp_port_arbiter #(
    parameter int ADR_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_ext,
    input  logic                 m0_req,
    input  logic                 m0_wr_rd,
    input  logic [ADR_SIZE-1:0]  m0_addr,
    input  logic [DATA_SIZE-1:0] m0_wdata,
    output logic                 m0_ack,
    output logic                 m0_gnt,
    output logic [DATA_SIZE-1:0] m0_rdata,
    output logic                 m0_rvalid,
    input  logic                 m1_req,
    input  logic                 m1_wr_rd,
    input  logic [ADR_SIZE-1:0]  m1_addr,
    input  logic [DATA_SIZE-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic                 m1_gnt,
    output logic [DATA_SIZE-1:0] m1_rdata,
    output logic                 m1_rvalid,
    output logic                 sp_en,
    output logic                 wr_rd_sp,
    output logic [ADR_SIZE-1:0]  SPA,
    output logic [DATA_SIZE-1:0] SPD_OUT,
    input  logic [DATA_SIZE-1:0] SPD_IN,
    output logic [1:0]           state_dbg
);

    // Handshake: mk_req (with its wr_rd/addr/wdata) is held until mk_ack; a beat
    // transfers in exactly the cycle where mk_req & mk_ack, and the master may
    // present its next beat in the following cycle. Read data returns on mk_rvalid.

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  sp_en_q, sp_en_d;
    logic                  wr_q, wr_d;
    logic [ADR_SIZE-1:0]   spa_q, spa_d;
    logic [DATA_SIZE-1:0]  spd_q, spd_d;
    logic                  mst_q, mst_d;
    logic [RD_LAT-1:0]     tag_v_q, tag_v_d;
    logic [RD_LAT-1:0]     tag_m_q, tag_m_d;
    logic                  burst_open;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        sp_en_d  = 1'b0;
        wr_d     = wr_q;
        spa_d    = spa_q;
        spd_d    = spd_q;
        mst_d    = mst_q;
        burst_open = (cnt_q < MAX_CNT);

        m0_ack = (state_q == OWN0) && m0_req && !stall_ext && burst_open;
        m1_ack = (state_q == OWN1) && m1_req && !stall_ext && burst_open;

        // A stall freezes the FSM and the burst count along with blocking acks.
        if (!stall_ext) begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (m0_req && m1_req) state_d = last_q ? OWN0 : OWN1;
                    else if (m0_req)      state_d = OWN0;
                    else if (m1_req)      state_d = OWN1;
                end
                OWN0: begin
                    if (!m0_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!burst_open) begin
                        cnt_d = '0;
                        if (m1_req) state_d = OWN1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OWN1: begin
                    if (!m1_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!burst_open) begin
                        cnt_d = '0;
                        if (m0_req) state_d = OWN0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (m0_ack) begin
            sp_en_d = 1'b1;
            wr_d    = m0_wr_rd;
            spa_d   = m0_addr;
            spd_d   = m0_wdata;
            mst_d   = 1'b0;
            last_d  = 1'b0;
        end else if (m1_ack) begin
            sp_en_d = 1'b1;
            wr_d    = m1_wr_rd;
            spa_d   = m1_addr;
            spd_d   = m1_wdata;
            mst_d   = 1'b1;
            last_d  = 1'b1;
        end

        // Tags enter when the read is on the port, so the last stage lines up with SPD_IN.
        tag_v_d    = tag_v_q;
        tag_m_d    = tag_m_q;
        tag_v_d[0] = sp_en_q && !wr_q;
        tag_m_d[0] = mst_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_m_d[i] = tag_m_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sp_en_q <= 1'b0;
            wr_q    <= 1'b0;
            spa_q   <= '0;
            spd_q   <= '0;
            mst_q   <= 1'b0;
            tag_v_q <= '0;
            tag_m_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sp_en_q <= sp_en_d;
            wr_q    <= wr_d;
            spa_q   <= spa_d;
            spd_q   <= spd_d;
            mst_q   <= mst_d;
            tag_v_q <= tag_v_d;
            tag_m_q <= tag_m_d;
        end
    end

    assign m0_gnt    = (state_q == OWN0);
    assign m1_gnt    = (state_q == OWN1);
    assign m0_rvalid = tag_v_q[RD_LAT-1] && !tag_m_q[RD_LAT-1];
    assign m1_rvalid = tag_v_q[RD_LAT-1] && tag_m_q[RD_LAT-1];
    assign m0_rdata  = SPD_IN;
    assign m1_rdata  = SPD_IN;
    assign sp_en     = sp_en_q;
    assign wr_rd_sp  = wr_q;
    assign SPA       = spa_q;
    assign SPD_OUT   = spd_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sp_port_arbiter.sv
// Directed bench for sp_port_arbiter: instance a (MAX_BURST=8, RD_LAT=1) and
// instance b (MAX_BURST=1, RD_LAT=3) share stimulus, each with its own SP memory.
module tb_sp_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_ext = 1'b0;
    logic        m0_req = 1'b0, m0_wr_rd = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_wr_rd = 1'b0;
    logic [15:0] m1_addr = '0, m1_wdata = '0;

    logic        a_m0_ack, a_m0_gnt, a_m0_rvalid, a_m1_ack, a_m1_gnt, a_m1_rvalid;
    logic [15:0] a_m0_rdata, a_m1_rdata, a_spa, a_spd_out, a_spd_in;
    logic        a_sp_en, a_wr_rd_sp;
    logic [1:0]  a_state;
    logic        b_m0_ack, b_m0_gnt, b_m0_rvalid, b_m1_ack, b_m1_gnt, b_m1_rvalid;
    logic [15:0] b_m0_rdata, b_m1_rdata, b_spa, b_spd_out, b_spd_in;
    logic        b_sp_en, b_wr_rd_sp;
    logic [1:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp_port_arbiter #(.ADR_SIZE(16), .DATA_SIZE(16), .MAX_BURST(8), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .stall_ext(stall_ext),
        .m0_req(m0_req), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(a_m0_ack), .m0_gnt(a_m0_gnt), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
        .m1_req(m1_req), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(a_m1_ack), .m1_gnt(a_m1_gnt), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
        .sp_en(a_sp_en), .wr_rd_sp(a_wr_rd_sp), .SPA(a_spa), .SPD_OUT(a_spd_out),
        .SPD_IN(a_spd_in), .state_dbg(a_state)
    );

    sp_port_arbiter #(.ADR_SIZE(16), .DATA_SIZE(16), .MAX_BURST(1), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .stall_ext(stall_ext),
        .m0_req(m0_req), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(b_m0_ack), .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
        .m1_req(m1_req), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(b_m1_ack), .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
        .sp_en(b_sp_en), .wr_rd_sp(b_wr_rd_sp), .SPA(b_spa), .SPD_OUT(b_spd_out),
        .SPD_IN(b_spd_in), .state_dbg(b_state)
    );

    // SP memory models: writes land at the clock edge, reads return after 1 / 3 cycles.
    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];
    logic [11:0] ra_a, rb0, rb1, rb2;

    always @(posedge clk) begin
        if (!rst) begin
            mem_a[12'h010] <= 16'hBEEF;
            mem_b[12'h020] <= 16'hA020;
            mem_b[12'h021] <= 16'hB021;
        end else begin
            if (a_sp_en && a_wr_rd_sp) mem_a[a_spa[11:0]] <= a_spd_out;
            if (b_sp_en && b_wr_rd_sp) mem_b[b_spa[11:0]] <= b_spd_out;
        end
        ra_a <= a_spa[11:0];
        rb0  <= b_spa[11:0];
        rb1  <= rb0;
        rb2  <= rb1;
    end

    assign a_spd_in = mem_a[ra_a];
    assign b_spd_in = mem_b[rb2];

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop_all();
        m0_req = 1'b0; m1_req = 1'b0; stall_ext = 1'b0;
        m0_wr_rd = 1'b0; m1_wr_rd = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b0;
        drop_all();
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    initial begin
        // Power-on reset values
        nxt();
        nxt();
        smp();
        chk("rst_gnt0", a_m0_gnt, 0);
        chk("rst_gnt1", a_m1_gnt, 0);
        chk("rst_sp_en", a_sp_en, 0);
        chk("rst_spa", a_spa, 0);
        chk("rst_spd_out", a_spd_out, 0);
        chk("rst_wr_rd", a_wr_rd_sp, 0);
        chk("rst_state", a_state, 0);
        chk("rst_rvalid", {a_m0_rvalid, a_m1_rvalid}, 0);
        nxt();
        rst = 1'b1;

        // Single read from m0 on instance a
        nxt(); m0_req = 1'b1; m0_wr_rd = 1'b0; m0_addr = 16'h0010;
        smp(); chk("rd_t0_ack", a_m0_ack, 0); chk("rd_t0_gnt", a_m0_gnt, 0);
        nxt();
        smp(); chk("rd_t1_gnt", a_m0_gnt, 1); chk("rd_t1_ack", a_m0_ack, 1); chk("rd_t1_sp_en", a_sp_en, 0);
        nxt(); m0_req = 1'b0;
        smp(); chk("rd_t2_sp_en", a_sp_en, 1); chk("rd_t2_spa", a_spa, 16'h0010); chk("rd_t2_wr", a_wr_rd_sp, 0);
        nxt();
        smp(); chk("rd_t3_rvalid0", a_m0_rvalid, 1); chk("rd_t3_rdata0", a_m0_rdata, 16'hBEEF);
        chk("rd_t3_rvalid1", a_m1_rvalid, 0); chk("rd_t3_gnt0", a_m0_gnt, 0);

        // Contention with MAX_BURST=8: 8 beats m0, bubble, 8 beats m1, bubble, m0
        do_reset();
        for (int c = 0; c < 20; c++) begin
            nxt();
            if (c == 0) begin
                m0_req = 1'b1; m0_wr_rd = 1'b1; m0_addr = 16'h0200; m0_wdata = 16'h0A0A;
                m1_req = 1'b1; m1_wr_rd = 1'b1; m1_addr = 16'h0300; m1_wdata = 16'h0B0B;
            end
            smp();
            chk($sformatf("cont_ack0_c%0d", c), a_m0_ack, ((c >= 1 && c <= 8) || c == 19) ? 1 : 0);
            chk($sformatf("cont_ack1_c%0d", c), a_m1_ack, (c >= 10 && c <= 17) ? 1 : 0);
            chk($sformatf("cont_gnt0_c%0d", c), a_m0_gnt, ((c >= 1 && c <= 9) || c == 19) ? 1 : 0);
            chk($sformatf("cont_gnt1_c%0d", c), a_m1_gnt, (c >= 10 && c <= 18) ? 1 : 0);
        end

        // m1 write burst of four with a two-cycle stall after beat 2
        do_reset();
        nxt(); m1_req = 1'b1; m1_wr_rd = 1'b1; m1_addr = 16'h0100; m1_wdata = 16'h1111;
        smp(); chk("st_c0_ack", a_m1_ack, 0);
        nxt();
        smp(); chk("st_c1_ack", a_m1_ack, 1); chk("st_c1_gnt", a_m1_gnt, 1);
        nxt(); m1_addr = 16'h0101; m1_wdata = 16'h2222;
        smp(); chk("st_c2_ack", a_m1_ack, 1); chk("st_c2_sp_en", a_sp_en, 1);
        chk("st_c2_spa", a_spa, 16'h0100); chk("st_c2_spd", a_spd_out, 16'h1111); chk("st_c2_wr", a_wr_rd_sp, 1);
        nxt(); m1_addr = 16'h0102; m1_wdata = 16'h3333; stall_ext = 1'b1;
        smp(); chk("st_c3_ack", a_m1_ack, 0); chk("st_c3_sp_en", a_sp_en, 1);
        chk("st_c3_spa", a_spa, 16'h0101); chk("st_c3_spd", a_spd_out, 16'h2222);
        nxt();
        smp(); chk("st_c4_ack", a_m1_ack, 0); chk("st_c4_sp_en", a_sp_en, 0);
        chk("st_c4_spa_hold", a_spa, 16'h0101); chk("st_c4_state", a_state, 2);
        nxt(); stall_ext = 1'b0;
        smp(); chk("st_c5_ack", a_m1_ack, 1); chk("st_c5_sp_en", a_sp_en, 0);
        nxt(); m1_addr = 16'h0103; m1_wdata = 16'h4444;
        smp(); chk("st_c6_ack", a_m1_ack, 1); chk("st_c6_spa", a_spa, 16'h0102); chk("st_c6_spd", a_spd_out, 16'h3333);
        nxt(); m1_req = 1'b0;
        smp(); chk("st_c7_sp_en", a_sp_en, 1); chk("st_c7_spa", a_spa, 16'h0103); chk("st_c7_spd", a_spd_out, 16'h4444);
        nxt();
        smp(); chk("st_c8_sp_en", a_sp_en, 0); chk("st_c8_gnt", a_m1_gnt, 0);
        chk("st_mem100", mem_a[12'h100], 16'h1111); chk("st_mem101", mem_a[12'h101], 16'h2222);
        chk("st_mem102", mem_a[12'h102], 16'h3333); chk("st_mem103", mem_a[12'h103], 16'h4444);

        // Read routing across owner switches on instance b (MAX_BURST=1, RD_LAT=3)
        do_reset();
        for (int c = 0; c < 14; c++) begin
            nxt();
            if (c == 0) begin
                m0_req = 1'b1; m0_wr_rd = 1'b0; m0_addr = 16'h0020;
                m1_req = 1'b1; m1_wr_rd = 1'b0; m1_addr = 16'h0021;
            end
            smp();
            chk($sformatf("rt_ack0_c%0d", c), b_m0_ack, (c % 4 == 1) ? 1 : 0);
            chk($sformatf("rt_ack1_c%0d", c), b_m1_ack, (c % 4 == 3) ? 1 : 0);
            chk($sformatf("rt_sp_en_c%0d", c), b_sp_en, (c >= 2 && c % 2 == 0) ? 1 : 0);
            chk($sformatf("rt_rv0_c%0d", c), b_m0_rvalid, (c >= 5 && c % 4 == 1) ? 1 : 0);
            chk($sformatf("rt_rv1_c%0d", c), b_m1_rvalid, (c >= 7 && c % 4 == 3) ? 1 : 0);
            if (c >= 5 && c % 4 == 1) chk($sformatf("rt_rd0_c%0d", c), b_m0_rdata, 16'hA020);
            if (c >= 7 && c % 4 == 3) chk($sformatf("rt_rd1_c%0d", c), b_m1_rdata, 16'hB021);
        end

        // Solo m0 burst of ten reads: bubble after beat 8, grant held throughout
        do_reset();
        for (int c = 0; c < 12; c++) begin
            nxt();
            if (c == 0) begin
                m0_req = 1'b1; m0_wr_rd = 1'b0; m0_addr = 16'h0010;
            end
            smp();
            chk($sformatf("solo_ack_c%0d", c), a_m0_ack, ((c >= 1 && c <= 8) || c >= 10) ? 1 : 0);
            chk($sformatf("solo_gnt_c%0d", c), a_m0_gnt, (c >= 1) ? 1 : 0);
        end
        nxt(); m0_req = 1'b0;

        // Reset one cycle after a read issue on instance b
        do_reset();
        nxt(); m0_req = 1'b1; m0_wr_rd = 1'b0; m0_addr = 16'h0020;
        nxt();
        smp(); chk("mr_c1_ack", b_m0_ack, 1);
        nxt(); m0_req = 1'b0;
        smp(); chk("mr_c2_sp_en", b_sp_en, 1);
        nxt(); rst = 1'b0;
        smp(); chk("mr_c3_sp_en", b_sp_en, 0); chk("mr_c3_spa", b_spa, 0); chk("mr_c3_gnt0", b_m0_gnt, 0);
        chk("mr_c3_state", b_state, 0); chk("mr_c3_rv", {b_m0_rvalid, b_m1_rvalid}, 0);
        nxt();
        nxt(); rst = 1'b1;
        smp(); chk("mr_c5_rv0", b_m0_rvalid, 0);
        nxt();
        smp(); chk("mr_c6_rv0", b_m0_rvalid, 0);
        nxt(); m0_req = 1'b1; m1_req = 1'b1;
        smp(); chk("mr_c7_ack0", b_m0_ack, 0);
        nxt();
        smp(); chk("mr_c8_gnt0", b_m0_gnt, 1); chk("mr_c8_gnt1", b_m1_gnt, 0);
        chk("mr_c8_ack0", b_m0_ack, 1); chk("mr_c8_a_gnt0", a_m0_gnt, 1);
        nxt(); drop_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
